// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU datapath constants and operand collector state encoding
package gpu_pkg;

   localparam int DATA_W   = 64;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ_A = 3'd1,
      READ_B = 3'd2,
      CAP_B  = 3'd3,
      VALID  = 3'd4
   } collector_state_t;

endpackage

// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - fetches two source operands through the shared register file port
// Writeback owns the register file port whenever it asks for it; operand reads
// simply stall in READ_A/READ_B until the port is free again.
module operand_collector
   import gpu_pkg::*;
#(
   parameter int OP_W   = 8,
   parameter int DATA_W = gpu_pkg::DATA_W,
   parameter int REG_W  = gpu_pkg::REG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              wb_valid,
   input  logic [REG_W-1:0]  wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic [31:0]       rf_register_num,
   output logic              rf_read,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_in,
   input  logic [DATA_W-1:0] rf_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OP_W-1:0]   out_op,
   output logic [REG_W-1:0]  out_rd,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b
);

   collector_state_t state;
   logic [REG_W-1:0] rs1_q;
   logic [REG_W-1:0] rs2_q;
   logic [REG_W-1:0] rs_sel;

   assign in_ready = (state == IDLE);
   assign rs_sel   = (state == READ_B) ? rs2_q : rs1_q;

   // Shared port mux: writeback wins; strobes are held off while in reset
   always_comb begin
      rf_write        = 1'b0;
      rf_read         = 1'b0;
      rf_in           = '0;
      rf_register_num = {{(32-REG_W){1'b0}}, rs_sel};
      if (wb_valid) begin
         rf_register_num = {{(32-REG_W){1'b0}}, wb_reg};
         rf_in           = wb_data;
      end
      if (rst_n) begin
         if (wb_valid) begin
            rf_write = 1'b1;
         end else begin
            rf_read = (state == READ_A) || (state == READ_B);
         end
      end
   end

   // Collection sequence: latch, read rs1, read rs2 (capturing rs1 data), capture rs2 data, present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rs1_q     <= '0;
         rs2_q     <= '0;
         out_valid <= 1'b0;
         out_op    <= '0;
         out_rd    <= '0;
         out_a     <= '0;
         out_b     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  out_op <= in_op;
                  out_rd <= in_rd;
                  rs1_q  <= in_rs1;
                  rs2_q  <= in_rs2;
                  state  <= READ_A;
               end
            end
            READ_A: begin
               if (!wb_valid) begin
                  state <= READ_B;
               end
            end
            READ_B: begin
               // rf_out keeps the rs1 data across stalls because writes never update it
               if (!wb_valid) begin
                  out_a <= rf_out;
                  state <= CAP_B;
               end
            end
            CAP_B: begin
               out_b     <= rf_out;
               out_valid <= 1'b1;
               state     <= VALID;
            end
            VALID: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - self-checking bench for operand_collector with a register file model
module tb_operand_collector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_op = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [4:0]  in_rd = '0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [63:0] wb_data = '0;
   logic [31:0] rf_register_num;
   logic        rf_read;
   logic        rf_write;
   logic [63:0] rf_in;
   logic [63:0] rf_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_op;
   logic [4:0]  out_rd;
   logic [63:0] out_a;
   logic [63:0] out_b;

   int checks = 0;
   int errors = 0;

   operand_collector #(.OP_W(8), .DATA_W(64), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_register_num(rf_register_num), .rf_read(rf_read), .rf_write(rf_write),
      .rf_in(rf_in), .rf_out(rf_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_rd(out_rd), .out_a(out_a), .out_b(out_b)
   );

   always #5 clk = ~clk;

   // Register file: writes update storage only, reads update the registered output
   logic [63:0] rf_mem [32];
   logic [63:0] rf_out_q;
   assign rf_out = rf_out_q;
   always @(posedge clk) begin
      if (rf_write) rf_mem[rf_register_num[4:0]] <= rf_in;
      else if (rf_read) rf_out_q <= rf_mem[rf_register_num[4:0]];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: an instruction needs two reads on cycles without writeback,
   // then one capture cycle, then it is presented until accepted.
   logic [63:0] mregs [32];
   bit          busy;
   int          reads_left;
   bit          capt;
   bit          mvalid;
   logic [4:0]  l_rs1, l_rs2, l_rd;
   logic [7:0]  l_op;
   logic [63:0] ea, eb;

   initial begin
      foreach (mregs[i]) mregs[i] = '0;
      busy = 0; reads_left = 0; capt = 0; mvalid = 0;
      l_rs1 = '0; l_rs2 = '0; l_rd = '0; l_op = '0; ea = '0; eb = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0; reads_left = 0; capt = 0; mvalid = 0;
         end
         chk("m_in_ready", in_ready, !busy);
         chk("m_rf_write", rf_write, rst_n && wb_valid);
         chk("m_rf_read", rf_read, rst_n && !wb_valid && (reads_left > 0));
         chk("m_rf_num_upper", rf_register_num[31:5], 0);
         if (rst_n && wb_valid) begin
            chk("m_rf_num_wb", rf_register_num, {27'b0, wb_reg});
            chk("m_rf_in", rf_in, wb_data);
         end else if (rst_n && reads_left > 0) begin
            chk("m_rf_num_rd", rf_register_num, {27'b0, (reads_left == 2) ? l_rs1 : l_rs2});
         end
         chk("m_out_valid", out_valid, mvalid);
         if (mvalid) begin
            chk("m_out_a", out_a, ea);
            chk("m_out_b", out_b, eb);
            chk("m_out_op", out_op, l_op);
            chk("m_out_rd", out_rd, l_rd);
         end
         if (rst_n) begin
            if (!busy) begin
               if (in_valid) begin
                  busy = 1; reads_left = 2;
                  l_rs1 = in_rs1; l_rs2 = in_rs2; l_rd = in_rd; l_op = in_op;
               end
            end else if (reads_left > 0) begin
               if (!wb_valid) begin
                  if (reads_left == 2) ea = mregs[l_rs1];
                  else begin
                     eb = mregs[l_rs2];
                     capt = 1;
                  end
                  reads_left--;
               end
            end else if (capt) begin
               capt = 0; mvalid = 1;
            end else if (mvalid && out_ready) begin
               mvalid = 0; busy = 0;
            end
            if (wb_valid) mregs[wb_reg] = wb_data;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] r, input logic [63:0] d);
      wb_valid = 1'b1; wb_reg = r; wb_data = d;
      step();
      wb_valid = 1'b0;
   endtask

   task automatic issue(input logic [7:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
      chk("issue_ready", in_ready, 1);
      in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = d;
      step();
      in_valid = 1'b0;
   endtask

   // Cycle number (relative to the accept edge) at which out_valid is first seen
   task automatic wait_valid(input int start, output int cyc);
      cyc = start;
      while (!out_valid && cyc < 60) begin
         step();
         cyc++;
      end
   endtask

   int c;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_op", out_op, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_rf_read", rf_read, 0);
      rst_n = 1'b1;
      step();

      // 1: basic collection
      wb(5'd3, 64'h1111);
      wb(5'd7, 64'h2222);
      issue(8'h05, 5'd3, 5'd7, 5'd9);
      wait_valid(1, c);
      chk("t1_latency", c, 4);
      chk("t1_out_a", out_a, 64'h1111);
      chk("t1_out_b", out_b, 64'h2222);
      chk("t1_out_op", out_op, 8'h05);
      chk("t1_out_rd", out_rd, 5'd9);
      step();
      chk("t1_idle_ready", in_ready, 1);
      chk("t1_idle_valid", out_valid, 0);

      // 2: two writeback cycles stall READ_A
      issue(8'h05, 5'd3, 5'd7, 5'd9);
      wb_valid = 1'b1; wb_reg = 5'd12; wb_data = 64'h1212;
      #1 chk("t2_stall_read0", rf_read, 0);
      step();
      chk("t2_stall_read1", rf_read, 0);
      step();
      wb_valid = 1'b0;
      wait_valid(3, c);
      chk("t2_latency", c, 6);
      chk("t2_out_a", out_a, 64'h1111);
      chk("t2_out_b", out_b, 64'h2222);
      step();
      issue(8'h06, 5'd12, 5'd3, 5'd10);
      wait_valid(1, c);
      chk("t2_r12_landed", out_a, 64'h1212);
      step();

      // 3a: writeback in the accept cycle, before the rs1 read
      wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 64'hAAAA;
      issue(8'h07, 5'd3, 5'd7, 5'd11);
      wb_valid = 1'b0;
      wait_valid(1, c);
      chk("t3_early_wb_a", out_a, 64'hAAAA);
      chk("t3_early_wb_b", out_b, 64'h2222);
      step();
      // 3b: writeback one cycle after the rs1 read
      issue(8'h07, 5'd3, 5'd7, 5'd11);
      step();
      wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 64'hBBBB;
      step();
      wb_valid = 1'b0;
      wait_valid(3, c);
      chk("t3_late_latency", c, 5);
      chk("t3_late_wb_a", out_a, 64'hAAAA);
      step();

      // 4: ALU backpressure
      out_ready = 1'b0;
      issue(8'h08, 5'd3, 5'd7, 5'd13);
      wait_valid(1, c);
      in_valid = 1'b1; in_op = 8'h09; in_rs1 = 5'd7; in_rs2 = 5'd12; in_rd = 5'd14;
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_hold_a", out_a, 64'hBBBB);
         chk("t4_hold_b", out_b, 64'h2222);
         chk("t4_hold_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("t4_after_hs_valid", out_valid, 0);
      chk("t4_after_hs_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("t4_accepted", in_ready, 0);
      wait_valid(1, c);
      chk("t4_next_latency", c, 4);
      chk("t4_next_a", out_a, 64'h2222);
      chk("t4_next_b", out_b, 64'h1212);
      chk("t4_next_rd", out_rd, 5'd14);
      step();

      // 5: asynchronous reset in READ_B
      issue(8'h01, 5'd3, 5'd7, 5'd15);
      step();
      chk("t5_readb_read", rf_read, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_read", rf_read, 0);
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_ready", in_ready, 1);
      wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 64'h5555;
      #1 chk("t5_rst_write", rf_write, 0);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      rst_n = 1'b1;
      chk("t5_cleared_a", out_a, 0);
      for (int i = 0; i < 6; i++) begin
         chk("t5_no_stale_valid", out_valid, 0);
         chk("t5_release_ready", in_ready, 1);
         step();
      end

      // 6: rs1 == rs2
      wb(5'd4, 64'h77);
      issue(8'h02, 5'd4, 5'd4, 5'd16);
      wait_valid(1, c);
      chk("t6_latency", c, 4);
      chk("t6_out_a", out_a, 64'h77);
      chk("t6_out_b", out_b, 64'h77);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Sits directly upstream of register_file, between the issue stage and the ALU.
- Accepts one decoded instruction (op, rs1, rs2, rd) per valid/ready handshake.
- Reads both source operands through register_file's single shared port, then presents op, rd and both 64-bit operands to the ALU on a valid/ready handshake.
- Arbitrates the shared port with the writeback path. Writeback always wins.

Parameters:
- OP_W, 8, width of the opaque opcode field passed through unchanged.
- DATA_W, 64, operand and register width; must match register_file.
- REG_W, 5, register index width (32 registers); register_num upper bits are driven zero.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  issue presents an instruction.
- in_ready  out  1  collector can accept an instruction.
- in_op  in  OP_W  opcode.
- in_rs1  in  REG_W  source A register.
- in_rs2  in  REG_W  source B register.
- in_rd  in  REG_W  destination register.
- wb_valid  in  1  writeback request this cycle; always accepted, no ready.
- wb_reg  in  REG_W  writeback register.
- wb_data  in  DATA_W  writeback data.
- rf_register_num  out  32  to register_file.register_num.
- rf_read  out  1  to register_file.read.
- rf_write  out  1  to register_file.write.
- rf_in  out  DATA_W  to register_file.in.
- rf_out  in  DATA_W  from register_file.out; registered, valid the cycle after an effective read, holds otherwise.
- out_valid  out  1  operands ready for ALU.
- out_ready  in  1  ALU accepts.
- out_op  out  OP_W  latched opcode.
- out_rd  out  REG_W  latched rd.
- out_a  out  DATA_W  operand from rs1.
- out_b  out  DATA_W  operand from rs2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid=0.
  - out_op, out_rd, out_a, out_b and the latched rs1/rs2 are cleared to 0.
  - rf_read=0 and rf_write=0 are forced combinationally while rst_n is low, even if wb_valid=1.
  - Reset mid-operation discards the in-flight instruction; no out_valid follows.
- Port mux, combinational:
  - wb_valid=1: rf_write=1, rf_read=0, rf_register_num={0,wb_reg}, rf_in=wb_data.
  - wb_valid=0: rf_write=0, rf_read=1 only in READ_A/READ_B, rf_register_num={0,rs_sel}, rf_in=0.
- A read is effective only in a cycle with rf_read=1, which implies wb_valid=0.
- State machine (states IDLE, READ_A, READ_B, CAP_B, VALID):
  - IDLE: in_ready=1. If in_valid, latch op/rs1/rs2/rd and go to READ_A.
  - READ_A: rs_sel=rs1. If wb_valid, stay in READ_A (stall). Else the read is effective; go to READ_B.
  - READ_B: rs_sel=rs2. If wb_valid, stay in READ_B. rf_out still holds rs1 data, because writes do not update out. Else out_a<=rf_out, the rs2 read is effective, and go to CAP_B.
  - CAP_B: out_b<=rf_out, go to VALID.
  - VALID: out_valid=1. Outputs are stable until out_ready. On out_ready go to IDLE and set out_valid=0 next cycle.
- in_ready=0 in every state except IDLE; no back-to-back overlap.
- Latency with no writeback:
  - Accept at edge 0.
  - Reads A and B in cycles 1 and 2.
  - Capture B at the end of cycle 3.
  - out_valid high from cycle 4.
  - Each wb_valid cycle spent in READ_A/READ_B adds one cycle.
  - Throughput is one instruction per 5 cycles when out_ready is held high.
- Hazards:
  - Operands reflect register contents at each effective read cycle.
  - A writeback to rs1/rs2 landing before that register's effective read is seen. One landing after it is not.
  - No bypass; dependency ordering is the scoreboard's job.
- rs1==rs2: both reads are still performed, and out_a==out_b unless a writeback to that register falls between them.
- Continuous wb_valid starves collection indefinitely. This is accepted behaviour, with no timeout.

Decomposition:
- Shared package gpu_pkg: constants DATA_W=64, REG_W=5, NUM_REGS=32, and the collector state enum (IDLE, READ_A, READ_B, CAP_B, VALID).
- No sub-module. The port mux and FSM stay in one module, instantiated beside register_file at the top level.

Test Plan:
1. Preload r3=0x1111, r7=0x2222 via wb. Issue op=0x05, rs1=3, rs2=7, rd=9 with out_ready=1 -> out_valid in cycle 4 with out_a=0x1111, out_b=0x2222, out_op=0x05, out_rd=9, then IDLE.
2. Same instruction, wb_valid for 2 cycles during READ_A -> rf_read held low those cycles, out_valid in cycle 6, operands correct; wb write to r12 lands.
3. wb to r3=0xAAAA in the cycle before the rs1 read -> out_a=0xAAAA. Same wb one cycle after the rs1 read -> out_a keeps the old value.
4. out_ready=0 for 3 cycles in VALID -> out_valid, out_a, out_b stable and in_ready=0 throughout; a new in_valid is not accepted until after the handshake.
5. rst_n low asynchronously in READ_B -> out_valid=0, rf_read=0, rf_write=0 immediately; after release in_ready=1 and no stale output appears.
6. rs1=rs2=4 (r4=0x77) -> out_a=out_b=0x77; rf_register_num upper 27 bits are always zero.
